// File: rtl/sram_pkg.sv
// Shared state encoding and word/mask helpers for the 1rw1r write-masked SRAM model.
package sram_pkg;

   typedef enum logic {INIT, RUN} sram_state_e;

   localparam int MAX_DATA_WIDTH = 1024;

   function automatic int num_wmasks(input int data_width, input int wmask_size);
      return data_width / wmask_size;
   endfunction

   function automatic int ram_depth(input int addr_width);
      return 1 << addr_width;
   endfunction

   // Operates on the widest supported word; callers size-cast in and out.
   function automatic logic [MAX_DATA_WIDTH-1:0] lane_merge(
      input logic [MAX_DATA_WIDTH-1:0] old_word,
      input logic [MAX_DATA_WIDTH-1:0] new_word,
      input logic [MAX_DATA_WIDTH-1:0] bit_mask
   );
      return (old_word & ~bit_mask) | (new_word & bit_mask);
   endfunction

endpackage

// File: rtl/sram_init_ctrl.sv
// Zero-fill init sequencer: walks every address once after reset, then holds ready.
module sram_init_ctrl
   import sram_pkg::*;
#(
   parameter int ADDR_WIDTH = 11
) (
   input  logic                  clk0,
   input  logic                  rst0,
   output logic                  ready,
   output logic                  init_we,
   output logic [ADDR_WIDTH-1:0] init_addr
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   sram_state_e           state, state_nxt;
   logic [ADDR_WIDTH-1:0] init_cnt, init_cnt_nxt;

   always_ff @(posedge clk0) begin
      if (rst0) begin
         state    <= INIT;
         init_cnt <= '0;
      end else begin
         state    <= state_nxt;
         init_cnt <= init_cnt_nxt;
      end
   end

   // The last address is written in the same cycle the FSM leaves INIT.
   always_comb begin
      state_nxt    = state;
      init_cnt_nxt = init_cnt;
      ready        = 1'b0;
      init_we      = 1'b0;
      case (state)
         INIT: begin
            init_we = 1'b1;
            if (init_cnt == LAST_ADDR) state_nxt = RUN;
            else                       init_cnt_nxt = init_cnt + 1'b1;
         end
         RUN:     ready = 1'b1;
         default: state_nxt = INIT;
      endcase
   end

   assign init_addr = init_cnt;

endmodule

// File: rtl/sram_1rw1r_wmask_model.sv
// Behavioural 1rw (byte-masked) + 1r SRAM with zero-fill init and collision pulse.
// Define SRAM_WRITE_FWD_EN to forward written lanes to a colliding port-1 read.
module sram_1rw1r_wmask_model
   import sram_pkg::*;
#(
   parameter  int DATA_WIDTH = 128,
   parameter  int ADDR_WIDTH = 11,
   parameter  int WMASK_SIZE = 8,
   localparam int NUM_WMASKS = num_wmasks(DATA_WIDTH, WMASK_SIZE)
) (
   input  logic                  clk0,
   input  logic                  rst0,
   input  logic                  csb0,
   input  logic                  web0,
   input  logic [NUM_WMASKS-1:0] wmask0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] din0,
   output logic [DATA_WIDTH-1:0] dout0,
   input  logic                  csb1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   output logic [DATA_WIDTH-1:0] dout1,
   output logic                  ready,
   output logic                  collision
);

   localparam int RAM_DEPTH = ram_depth(ADDR_WIDTH);

   logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

   logic                  csb0_reg, web0_reg, csb1_reg;
   logic [NUM_WMASKS-1:0] wmask0_reg;
   logic [ADDR_WIDTH-1:0] addr0_reg, addr1_reg;
   logic [DATA_WIDTH-1:0] din0_reg;

   logic                  init_we;
   logic [ADDR_WIDTH-1:0] init_addr;
   logic                  wr_en, rd0_en, rd1_en, hit;
   logic [DATA_WIDTH-1:0] bit_mask, wr_word, fwd_word, rd1_word;

   sram_init_ctrl #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_init_ctrl (
      .clk0      (clk0),
      .rst0      (rst0),
      .ready     (ready),
      .init_we   (init_we),
      .init_addr (init_addr)
   );

   always_comb begin
      bit_mask = '0;
      for (int i = 0; i < NUM_WMASKS; i++)
         bit_mask[i*WMASK_SIZE +: WMASK_SIZE] = {WMASK_SIZE{wmask0_reg[i]}};
   end

   assign wr_en  = !csb0_reg && !web0_reg;
   assign rd0_en = !csb0_reg &&  web0_reg;
   assign rd1_en = !csb1_reg;
   assign hit    = wr_en && rd1_en && (addr0_reg == addr1_reg);

`ifdef SRAM_WRITE_FWD_EN
   assign fwd_word = din0_reg;
`else
   assign fwd_word = 'x;
`endif

   assign wr_word  = DATA_WIDTH'(lane_merge(MAX_DATA_WIDTH'(mem[addr0_reg]),
                                            MAX_DATA_WIDTH'(din0_reg),
                                            MAX_DATA_WIDTH'(bit_mask)));
   assign rd1_word = hit ? DATA_WIDTH'(lane_merge(MAX_DATA_WIDTH'(mem[addr1_reg]),
                                                  MAX_DATA_WIDTH'(fwd_word),
                                                  MAX_DATA_WIDTH'(bit_mask)))
                         : mem[addr1_reg];

   // A write caught by reset is dropped; the init fill owns the array otherwise.
   always_ff @(posedge clk0) begin
      if (!rst0 && wr_en) mem[addr0_reg] <= wr_word;
      else if (init_we)   mem[init_addr] <= '0;
   end

   always_ff @(posedge clk0) begin
      if (rst0) begin
         csb0_reg   <= 1'b1;
         web0_reg   <= 1'b1;
         wmask0_reg <= '0;
         addr0_reg  <= '0;
         din0_reg   <= '0;
         csb1_reg   <= 1'b1;
         addr1_reg  <= '0;
         dout0      <= '0;
         dout1      <= '0;
         collision  <= 1'b0;
      end else begin
         csb0_reg   <= csb0 | ~ready;
         web0_reg   <= web0;
         wmask0_reg <= wmask0;
         addr0_reg  <= addr0;
         din0_reg   <= din0;
         csb1_reg   <= csb1 | ~ready;
         addr1_reg  <= addr1;
         collision  <= hit;
         if (rd0_en) dout0 <= mem[addr0_reg];
         if (rd1_en) dout1 <= rd1_word;
      end
   end

endmodule
